// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory port arbiter.
//   state_e      arbiter FSM state encoding
//   GRANT_*      encoding of the last-granted requester (round-robin memory)
//   *_DFLT       default legal address regions for fetch and data ports
package mem_port_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_BUSY_I = 3'd1,
    ST_BUSY_D = 3'd2,
    ST_RESP_I = 3'd3,
    ST_RESP_D = 3'd4
  } state_e;

  localparam logic GRANT_INSTR = 1'b0;
  localparam logic GRANT_DATA  = 1'b1;

  localparam logic [31:0] INSTR_BASE_DFLT  = 32'h0000_0000;
  localparam logic [31:0] INSTR_LIMIT_DFLT = 32'h0000_FFFF;
  localparam logic [31:0] DATA_BASE_DFLT   = 32'h0001_0000;
  localparam logic [31:0] DATA_LIMIT_DFLT  = 32'h0001_FFFF;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch port, the data port and the backing-memory bus of the
// arbiter.
//   master : arbiter view (drives responses, waits and the memory strobes)
//   slave  : environment view (requesters plus the memory model)
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              instr_req;
  logic [ADDR_W-1:0] instr_addr;
  logic [DATA_W-1:0] instr;
  logic              wait_instr;
  logic              instr_segv;

  logic              rd;
  logic              wd;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data;
  logic              wait_data;
  logic              data_segv;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rd;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    input  instr_req, instr_addr, rd, wd, data_addr, data_in, mem_rdata, mem_ack,
    output instr, wait_instr, instr_segv, data, wait_data, data_segv,
           mem_addr, mem_wdata, mem_rd, mem_wr
  );

  modport slave (
    output instr_req, instr_addr, rd, wd, data_addr, data_in, mem_rdata, mem_ack,
    input  instr, wait_instr, instr_segv, data, wait_data, data_segv,
           mem_addr, mem_wdata, mem_rd, mem_wr
  );
endinterface

// File: rtl/mem_port_arbiter_addr_checker.sv
// Combinational legality check for one request port.
//   addr_i : requested address
//   ok_o   : 1 when addr_i lies in [BASE, LIMIT] and is word aligned
module mem_port_arbiter_addr_checker #(
  parameter int                ADDR_W = 32,
  parameter logic [ADDR_W-1:0] BASE   = '0,
  parameter logic [ADDR_W-1:0] LIMIT  = '1
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic              ok_o
);
  logic [ADDR_W-1:0] offset;

  // One unsigned subtract covers both bounds (addresses below BASE wrap
  // to large offsets) and avoids a constant compare when BASE is zero.
  assign offset = addr_i - BASE;
  assign ok_o   = (offset <= (LIMIT - BASE)) && (addr_i[1:0] == 2'b00);
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data
// load/store. Arbitrates (round-robin on conflict), range/alignment checks,
// runs the mem_rd/mem_wr + mem_ack handshake with a timeout, and returns the
// result in a one-cycle registered response.
//   clk, reset : clock and synchronous active-high reset
//   bus        : fetch port, data port and memory bus (master modport)
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | no access in flight, arbitrate pending requests
// BUSY_I  | fetch strobe on memory, waiting for mem_ack
// BUSY_D  | load/store strobe on memory, waiting for mem_ack
// RESP_I  | instr/instr_segv valid, wait_instr low
// RESP_D  | data/data_segv valid, wait_data low
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter logic [ADDR_W-1:0] INSTR_BASE  = ADDR_W'(INSTR_BASE_DFLT),
  parameter logic [ADDR_W-1:0] INSTR_LIMIT = ADDR_W'(INSTR_LIMIT_DFLT),
  parameter logic [ADDR_W-1:0] DATA_BASE   = ADDR_W'(DATA_BASE_DFLT),
  parameter logic [ADDR_W-1:0] DATA_LIMIT  = ADDR_W'(DATA_LIMIT_DFLT),
  parameter int                TIMEOUT     = 255
) (
  input logic                clk,
  input logic                reset,
  mem_port_arbiter_if.master bus
);
  localparam int              CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT - 1);

  state_e            state_q;
  logic              last_grant_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              mem_rd_q, mem_wr_q;
  logic [DATA_W-1:0] instr_q, data_q;
  logic              instr_segv_q, data_segv_q;

  logic instr_ok, data_ok;
  logic instr_pend, data_pend, grant_data_d, data_fault;

  mem_port_arbiter_addr_checker #(
    .ADDR_W(ADDR_W), .BASE(INSTR_BASE), .LIMIT(INSTR_LIMIT)
  ) u_instr_chk (
    .addr_i(bus.instr_addr), .ok_o(instr_ok)
  );

  mem_port_arbiter_addr_checker #(
    .ADDR_W(ADDR_W), .BASE(DATA_BASE), .LIMIT(DATA_LIMIT)
  ) u_data_chk (
    .addr_i(bus.data_addr), .ok_o(data_ok)
  );

  assign instr_pend = bus.instr_req;
  assign data_pend  = bus.rd | bus.wd;
  assign data_fault = ~data_ok | (bus.rd & bus.wd);
  // Data wins when it is alone, or on a conflict after an instruction grant.
  assign grant_data_d = data_pend & (~instr_pend | (last_grant_q == GRANT_INSTR));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GRANT_INSTR;
      cnt_q        <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      instr_q      <= '0;
      data_q       <= '0;
      instr_segv_q <= 1'b0;
      data_segv_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (instr_pend | data_pend) begin
            last_grant_q <= grant_data_d ? GRANT_DATA : GRANT_INSTR;
            cnt_q        <= CNT_LOAD;
            if (grant_data_d) begin
              if (data_fault) begin
                state_q     <= ST_RESP_D;
                data_segv_q <= 1'b1;
                data_q      <= '0;
              end else begin
                state_q     <= ST_BUSY_D;
                mem_addr_q  <= bus.data_addr;
                mem_wdata_q <= bus.data_in;
                mem_rd_q    <= bus.rd;
                mem_wr_q    <= bus.wd;
              end
            end else begin
              if (!instr_ok) begin
                state_q      <= ST_RESP_I;
                instr_segv_q <= 1'b1;
                instr_q      <= '0;
              end else begin
                state_q     <= ST_BUSY_I;
                mem_addr_q  <= bus.instr_addr;
                mem_wdata_q <= '0;
                mem_rd_q    <= 1'b1;
              end
            end
          end
        end
        ST_BUSY_I, ST_BUSY_D: begin
          // An ack in the last allowed cycle still completes normally.
          if (bus.mem_ack || (cnt_q == '0)) begin
            mem_rd_q <= 1'b0;
            mem_wr_q <= 1'b0;
            if (state_q == ST_BUSY_I) begin
              state_q      <= ST_RESP_I;
              instr_segv_q <= ~bus.mem_ack;
              instr_q      <= bus.mem_ack ? bus.mem_rdata : '0;
            end else begin
              state_q     <= ST_RESP_D;
              data_segv_q <= ~bus.mem_ack;
              data_q      <= (bus.mem_ack && mem_rd_q) ? bus.mem_rdata : '0;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_RESP_I, ST_RESP_D: state_q <= ST_IDLE;
        default:              state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.mem_rd     = mem_rd_q;
  assign bus.mem_wr     = mem_wr_q;
  assign bus.instr      = instr_q;
  assign bus.data       = data_q;
  assign bus.instr_segv = instr_segv_q;
  assign bus.data_segv  = data_segv_q;
  assign bus.wait_instr = bus.instr_req & (state_q != ST_RESP_I);
  assign bus.wait_data  = (bus.rd | bus.wd) & (state_q != ST_RESP_D);
endmodule
